// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: CPU/loader request ports and the shared data RAM port of dm_arbiter.
interface dm_arbiter_if;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] ram_pc, ram_addr, ram_data, ram_out;
  logic        ram_isWD;
  modport slave (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata, m0_pc,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata, ram_out,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    output ram_pc, ram_addr, ram_data, ram_isWD
  );
  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata, m0_pc,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata, ram_out,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    input  ram_pc, ram_addr, ram_data, ram_isWD
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the data RAM port between CPU (m0) and loader (m1),
// with starvation override and two-cycle read-modify-write for partial stores.
module dm_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RMW_WR} state_t;
  state_t      state, state_nx;
  logic [3:0]  starve_cnt, lat_be, sel_be;
  logic [31:0] lat_addr, lat_wdata, lat_pc, old_word, merged;
  logic [31:0] sel_addr, sel_wdata, sel_pc;
  logic        idle, m0_win, m1_win, any_win, sel_we, partial;
  // Grants are gated by reset so nothing is accepted while reset is held.
  always_comb begin
    idle = state == IDLE && !reset;
    m1_win = idle && bus.m1_req && (!bus.m0_req || starve_cnt == 4'(STARVE_LIMIT));
    m0_win = idle && bus.m0_req && !m1_win;
    any_win = m0_win || m1_win;
    sel_we = m1_win ? bus.m1_we : bus.m0_we;
    sel_be = m1_win ? bus.m1_be : bus.m0_be;
    sel_addr = m1_win ? bus.m1_addr : bus.m0_addr;
    sel_wdata = m1_win ? bus.m1_wdata : bus.m0_wdata;
    sel_pc = m1_win ? 32'd0 : bus.m0_pc;
    partial = any_win && sel_we && sel_be != 4'h0 && sel_be != 4'hf;
    merged = old_word;
    for (int i = 0; i < 4; i++)
      if (lat_be[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
  end
  always_comb begin
    state_nx = state;
    bus.m0_gnt = m0_win;
    bus.m1_gnt = m1_win;
    bus.ram_addr = 32'd0;
    bus.ram_data = 32'd0;
    bus.ram_pc = 32'd0;
    bus.ram_isWD = 1'b0;
    if (state == RMW_WR) begin
      state_nx = IDLE;
      bus.ram_addr = lat_addr;
      bus.ram_data = merged;
      bus.ram_pc = lat_pc;
      bus.ram_isWD = 1'b1;
    end else if (any_win) begin
      state_nx = partial ? RMW_WR : IDLE;
      bus.ram_addr = sel_addr;
      bus.ram_data = sel_we ? sel_wdata : 32'd0;
      bus.ram_pc = sel_pc;
      bus.ram_isWD = sel_we && sel_be == 4'hf;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      starve_cnt <= 4'd0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata <= 32'd0;
      bus.m1_rdata <= 32'd0;
      lat_addr <= 32'd0;
      lat_wdata <= 32'd0;
      lat_pc <= 32'd0;
      lat_be <= 4'd0;
      old_word <= 32'd0;
    end else begin
      bus.m0_rvalid <= m0_win && !bus.m0_we;
      bus.m1_rvalid <= m1_win && !bus.m1_we;
      if (m0_win && !bus.m0_we) bus.m0_rdata <= bus.ram_out;
      if (m1_win && !bus.m1_we) bus.m1_rdata <= bus.ram_out;
      // starve_cnt only moves in IDLE; an RMW_WR cycle is not a lost arbitration.
      if (state == IDLE)
        starve_cnt <= bus.m1_req && !m1_win ?
          (starve_cnt == 4'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
      if (partial) begin
        lat_addr <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_pc <= sel_pc;
        lat_be <= sel_be;
        old_word <= bus.ram_out;
      end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized scoreboard bench for dm_arbiter against a
// transaction-level memory and arbitration model.
module tb_dm_arbiter;
  localparam int LIMIT = 4;
  typedef struct {logic we; logic [3:0] be; logic [31:0] addr, wdata, pc;} op_t;
  typedef struct {logic [31:0] data; int cyc;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  dm_arbiter_if bus();
  dm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] ram [4096];
  assign bus.ram_out = ram[bus.ram_addr[13:2]];
  always @(posedge clk) if (bus.ram_isWD) ram[bus.ram_addr[13:2]] <= bus.ram_data;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_pass = 0;
  op_t q0[$], q1[$], cur[2];
  bit act[2];
  exp_t eq0[$], eq1[$];
  int wins[$];
  logic [31:0] ref_mem [int];
  bit rmw_p;
  logic [31:0] rmw_addr, rmw_word;
  int wait1;
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask
  function automatic logic [31:0] rd(logic [31:0] a);
    return ref_mem.exists(int'(a[13:2])) ? ref_mem[int'(a[13:2])] : 32'd0;
  endfunction
  function automatic op_t mk(logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wdata, logic [31:0] pc);
    op_t o;
    o.we = we; o.be = be; o.addr = addr; o.wdata = wdata; o.pc = pc;
    return o;
  endfunction
  function automatic op_t rnd(bit m);
    int k = int'($urandom_range(0, 3));
    logic [3:0] be = k == 0 ? 4'hf : k == 1 ? 4'h0 : 4'($urandom);
    return mk(1'($urandom), be, 32'h40 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
              $urandom, m ? 32'd0 : $urandom);
  endfunction
  task automatic drive();
    bus.m0_req = act[0]; bus.m0_we = cur[0].we; bus.m0_be = cur[0].be;
    bus.m0_addr = cur[0].addr; bus.m0_wdata = cur[0].wdata; bus.m0_pc = cur[0].pc;
    bus.m1_req = act[1]; bus.m1_we = cur[1].we; bus.m1_be = cur[1].be;
    bus.m1_addr = cur[1].addr; bus.m1_wdata = cur[1].wdata;
  endtask
  // One clock: present requests after the edge, then judge the accept at the negedge.
  task automatic step();
    int exp_w, got;
    op_t o;
    logic [31:0] w, mask;
    exp_t e;
    @(posedge clk); #1;
    if (!act[0] && q0.size() != 0) begin cur[0] = q0.pop_front(); act[0] = 1; end
    if (!act[1] && q1.size() != 0) begin cur[1] = q1.pop_front(); act[1] = 1; end
    drive();
    @(negedge clk);
    if (rmw_p) begin
      exp_w = -1;
      chk("rmw_we", 32'(bus.ram_isWD), 1);
      chk("rmw_addr", bus.ram_addr, rmw_addr);
      chk("rmw_data", bus.ram_data, rmw_word);
      ref_mem[int'(rmw_addr[13:2])] = rmw_word;
      rmw_p = 0;
    end else begin
      exp_w = act[1] && (!act[0] || wait1 == LIMIT) ? 1 : act[0] ? 0 : -1;
      wait1 = act[1] && exp_w != 1 ? (wait1 < LIMIT ? wait1 + 1 : LIMIT) : 0;
    end
    got = bus.m0_gnt && bus.m1_gnt ? 2 : bus.m1_gnt ? 1 : bus.m0_gnt ? 0 : -1;
    chk("grant", got, exp_w);
    if (got == 0 || got == 1) begin
      o = cur[got];
      act[got] = 0;
      wins.push_back(got);
      chk("ram_addr", bus.ram_addr, o.addr);
      chk("ram_pc", bus.ram_pc, got == 0 ? o.pc : 32'd0);
      w = rd(o.addr);
      if (!o.we) begin
        chk("read_we", 32'(bus.ram_isWD), 0);
        e.data = w; e.cyc = cyc + 1;
        if (got == 0) eq0.push_back(e); else eq1.push_back(e);
      end else if (o.be == 4'hf) begin
        chk("full_we", 32'(bus.ram_isWD), 1);
        chk("full_data", bus.ram_data, o.wdata);
        ref_mem[int'(o.addr[13:2])] = o.wdata;
      end else if (o.be == 4'h0) begin
        chk("noop_we", 32'(bus.ram_isWD), 0);
      end else begin
        chk("rmw_accept_we", 32'(bus.ram_isWD), 0);
        mask = {{8{o.be[3]}}, {8{o.be[2]}}, {8{o.be[1]}}, {8{o.be[0]}}};
        rmw_p = 1;
        rmw_addr = o.addr;
        rmw_word = (w & ~mask) | (o.wdata & mask);
      end
    end
  endtask
  task automatic run(int maxc);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || act[0] || act[1] || rmw_p) && n < maxc) begin
      step();
      n++;
    end
    if (n >= maxc) chk("run_timeout", 32'(n), 32'(maxc - 1));
    repeat (2) step();
  endtask
  // Read-data monitor: pops the scoreboard whenever a read returns.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (bus.m0_rvalid) begin
        if (eq0.size() == 0) chk("m0_rvalid_spurious", 32'(bus.m0_rvalid), 0);
        else begin
          e = eq0.pop_front();
          chk("m0_rdata", bus.m0_rdata, e.data);
          chk("m0_rvalid_cycle", cyc, e.cyc);
        end
      end else if (eq0.size() != 0 && eq0[0].cyc <= cyc) begin
        chk("m0_rvalid_missing", 32'(bus.m0_rvalid), 1);
        void'(eq0.pop_front());
      end
      if (bus.m1_rvalid) begin
        if (eq1.size() == 0) chk("m1_rvalid_spurious", 32'(bus.m1_rvalid), 0);
        else begin
          e = eq1.pop_front();
          chk("m1_rdata", bus.m1_rdata, e.data);
          chk("m1_rvalid_cycle", cyc, e.cyc);
        end
      end else if (eq1.size() != 0 && eq1[0].cyc <= cyc) begin
        chk("m1_rvalid_missing", 32'(bus.m1_rvalid), 1);
        void'(eq1.pop_front());
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n;
    cur[0] = mk(0, 0, 0, 0, 0);
    cur[1] = mk(0, 0, 0, 0, 0);
    drive();
    bus.m0_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_m0_gnt", 32'(bus.m0_gnt), 0);
    chk("reset_m1_gnt", 32'(bus.m1_gnt), 0);
    chk("reset_m0_rvalid", 32'(bus.m0_rvalid), 0);
    chk("reset_m1_rvalid", 32'(bus.m1_rvalid), 0);
    chk("reset_m0_rdata", bus.m0_rdata, 0);
    chk("reset_m1_rdata", bus.m1_rdata, 0);
    chk("reset_ram_we", 32'(bus.ram_isWD), 0);
    bus.m0_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    // full write then read back
    q0.push_back(mk(1, 4'hf, 32'h10, 32'hDEADBEEF, 32'h100));
    q0.push_back(mk(0, 4'h0, 32'h10, 32'h0, 32'h104));
    run(50);
    // byte store via read-modify-write
    q0.push_back(mk(1, 4'b0010, 32'h10, 32'h0000_5500, 32'h108));
    q0.push_back(mk(0, 4'h0, 32'h10, 32'h0, 32'h10c));
    run(50);
    // continuous contention: m1 wins every fifth arbitration
    wins.delete();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(mk(0, 4'h0, 32'h10, 32'h0, 32'h200 + 32'(4 * i)));
      q1.push_back(mk(0, 4'h0, 32'h10, 32'h0, 32'h0));
    end
    run(100);
    for (int i = 0; i < 10; i++)
      chk("starve_pattern", i < wins.size() ? 32'(wins[i]) : 32'hffffffff, (i % 5 == 4) ? 32'd1 : 32'd0);
    // partial write while m1 waits
    q0.push_back(mk(1, 4'b0100, 32'h10, 32'h0077_0000, 32'h300));
    q0.push_back(mk(0, 4'h0, 32'h10, 32'h0, 32'h304));
    q1.push_back(mk(0, 4'h0, 32'h10, 32'h0, 32'h0));
    run(50);
    // m1 zero-byte write is a no-op
    q1.push_back(mk(1, 4'h0, 32'h10, 32'hFFFF_FFFF, 32'h0));
    q0.push_back(mk(0, 4'h0, 32'h10, 32'h0, 32'h310));
    run(50);
    // reset in the middle of an RMW_WR cycle
    q0.push_back(mk(1, 4'hf, 32'h20, 32'h1122_3344, 32'h400));
    q0.push_back(mk(1, 4'b1000, 32'h20, 32'hAA00_0000, 32'h404));
    n = 0;
    while (!rmw_p && n < 20) begin step(); n++; end
    chk("rmw_reached", 32'(rmw_p), 1);
    @(posedge clk); #1;
    drive();
    chk("rmw_before_reset", 32'(bus.ram_isWD), 1);
    reset = 1'b1;
    #1;
    chk("abort_ram_we", 32'(bus.ram_isWD), 0);
    chk("abort_ram_addr", bus.ram_addr, 0);
    chk("abort_ram_data", bus.ram_data, 0);
    chk("abort_m0_gnt", 32'(bus.m0_gnt), 0);
    chk("abort_m1_gnt", 32'(bus.m1_gnt), 0);
    chk("abort_m0_rvalid", 32'(bus.m0_rvalid), 0);
    chk("abort_m1_rvalid", 32'(bus.m1_rvalid), 0);
    chk("abort_m0_rdata", bus.m0_rdata, 0);
    chk("abort_m1_rdata", bus.m1_rdata, 0);
    rmw_p = 0;
    wait1 = 0;
    eq0.delete();
    eq1.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    q1.push_back(mk(0, 4'h0, 32'h20, 32'h0, 32'h0));
    run(50);
    // random traffic over a small set of words
    for (int i = 0; i < 8; i++) q1.push_back(mk(1, 4'hf, 32'h40 + 32'(4 * i), $urandom, 32'h0));
    run(50);
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) != 0) q0.push_back(rnd(0));
      if (q1.size() == 0 && $urandom_range(0, 1) != 0) q1.push_back(rnd(1));
      step();
    end
    run(400);
    chk("m0_reads_outstanding", 32'(eq0.size()), 0);
    chk("m1_reads_outstanding", 32'(eq1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
